sdfm_data_fifo: RTL and testbench

- Per-channel output buffer sitting directly downstream of each sigma-delta CHANNEL filter and upstream of REGMAP/IRQ.
- Captures each filtered word presented with a one-cycle valid strobe, stores it in a first-word-fall-through FIFO, and exposes the head word to the register read path.
- Generates a sticky interrupt request on a programmable fill level and on overflow; one instance per channel, with IRQs ORed at top level.

---
 rtl/sdfm_pkg.sv | 24 ++
 rtl/sdfm_fifo_mem.sv | 32 +++
 rtl/sdfm_data_fifo.sv | 130 +++++++++++++
 tb/tb_sdfm_data_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdfm_pkg                                                             |
// | Shared sizes and status-flag layout for the SDFM output FIFO.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sdfm_pkg;

  localparam int unsigned SDFM_DW         = 32;
  localparam int unsigned SDFM_FIFO_DEPTH = 16;

  localparam int unsigned SDFM_FLAG_OVF = 0;
  localparam int unsigned SDFM_FLAG_UDF = 1;
  localparam int unsigned SDFM_FLAG_IRQ = 2;

  // Packed so that the bit positions match the status register layout.
  typedef struct packed {
    logic irq;
    logic udf;
    logic ovf;
  } sdfm_flags_t;

endpackage
`default_nettype wire

// File: rtl/sdfm_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdfm_fifo_mem                                                        |
// | DEPTH x DW register array, one write port, asynchronous read port.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sdfm_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Contents need no reset; occupancy is tracked by the owner.
  logic [DW-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sdfm_data_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdfm_data_fifo                                                       |
// | Per-channel FWFT output FIFO with sticky level/overflow interrupt.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sdfm_data_fifo
  import sdfm_pkg::*;
#(
  parameter int unsigned DEPTH = SDFM_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = SDFM_DW
) (
  input  logic          SYSCLK,
  input  logic          SYSRST,
  input  logic          reg_fifoen,
  input  logic [AW:0]   reg_fifolvl,
  input  logic          reg_lvlie,
  input  logic          reg_ovfie,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          rd_pop,
  input  logic          clr_flags,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          ovf_flag,
  output logic          udf_flag,
  output logic          irq
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  sdfm_flags_t   flags_q,  flags_d;

  logic [DW-1:0] mem_rdata;
  logic [AW:0]   eff_lvl;
  logic          empty, full;
  logic          push_req, pop_req, do_push, do_pop;
  logic          ovf_evt, udf_evt, lvl_evt;

  // A full FIFO still accepts a push when the same cycle pops a word.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    push_req = in_valid & reg_fifoen;
    pop_req  = rd_pop & reg_fifoen;
    do_pop   = pop_req & ~empty;
    do_push  = push_req & (~full | do_pop);
    ovf_evt  = push_req & full & ~do_pop;
    udf_evt  = pop_req & empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!reg_fifoen) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Thresholds above DEPTH can never be reached, so no extra guard needed.
  always_comb begin
    eff_lvl = (reg_fifolvl == '0) ? CNT_ONE : reg_fifolvl;
    lvl_evt = (count_q < eff_lvl) && (count_d >= eff_lvl);
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    flags_d     = flags_q;
    flags_d.ovf = ovf_evt | (flags_q.ovf & ~clr_flags);
    flags_d.udf = udf_evt | (flags_q.udf & ~clr_flags);
    flags_d.irq = (lvl_evt & reg_lvlie) | (ovf_evt & reg_ovfie)
                | (flags_q.irq & ~clr_flags);
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  sdfm_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk_i   (SYSCLK),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign rd_data    = empty ? '0 : mem_rdata;
  assign fifo_count = count_q;
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign ovf_flag   = flags_q.ovf;
  assign udf_flag   = flags_q.udf;
  assign irq        = flags_q.irq;

endmodule
`default_nettype wire

// File: tb/tb_sdfm_data_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdfm_data_fifo                                                    |
// | Scoreboard bench: directed scenarios followed by random traffic.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sdfm_data_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic          SYSCLK = 1'b0;
  logic          SYSRST;
  logic          reg_fifoen;
  logic [AW:0]   reg_fifolvl;
  logic          reg_lvlie, reg_ovfie;
  logic [DW-1:0] in_data;
  logic          in_valid, rd_pop, clr_flags;
  logic [DW-1:0] rd_data;
  logic [AW:0]   fifo_count;
  logic          fifo_empty, fifo_full, ovf_flag, udf_flag, irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  int          m_count = 0;
  bit          m_ovf = 0, m_udf = 0, m_irq = 0;

  sdfm_data_fifo dut (
    .SYSCLK      (SYSCLK),
    .SYSRST      (SYSRST),
    .reg_fifoen  (reg_fifoen),
    .reg_fifolvl (reg_fifolvl),
    .reg_lvlie   (reg_lvlie),
    .reg_ovfie   (reg_ovfie),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .rd_pop      (rd_pop),
    .clr_flags   (clr_flags),
    .rd_data     (rd_data),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .ovf_flag    (ovf_flag),
    .udf_flag    (udf_flag),
    .irq         (irq)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as an integer, contents in the queue.
  task automatic model_edge(input bit v, input logic [31:0] d, input bit p, input bit c);
    int  lvl;
    int  nxt;
    bit  pop_ok, push_ok, ovf, udf, lev;
    ovf = 0; udf = 0; lev = 0;
    lvl = (reg_fifolvl == 0) ? 1 : int'(reg_fifolvl);
    if (!reg_fifoen) begin
      sb.delete();
      m_count = 0;
    end else begin
      pop_ok  = p && (m_count > 0);
      push_ok = v && ((m_count < DEPTH) || pop_ok);
      ovf     = v && !push_ok;
      udf     = p && (m_count == 0);
      nxt     = m_count + int'(push_ok) - int'(pop_ok);
      lev     = (m_count < lvl) && (nxt >= lvl);
      if (push_ok) sb.push_back(d);
      m_count = nxt;
    end
    m_ovf = ovf || (m_ovf && !c);
    m_udf = udf || (m_udf && !c);
    m_irq = (lev && reg_lvlie) || (ovf && reg_ovfie) || (m_irq && !c);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit v, input logic [31:0] d, input bit p, input bit c);
    in_valid  = v;
    in_data   = d;
    rd_pop    = p;
    clr_flags = c;
    @(posedge SYSCLK);
    model_edge(v, d, p, c);
    #1;
    in_valid  = 1'b0;
    rd_pop    = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0);
  endtask

  // Monitor: compares visible state and the head word each cycle, and
  // retires the head from the scoreboard when a real pop is about to occur.
  always @(negedge SYSCLK) begin
    if (!SYSRST) begin
      chk("count", 32'(fifo_count), 32'(m_count));
      chk("empty", 32'(fifo_empty), 32'(m_count == 0));
      chk("full",  32'(fifo_full),  32'(m_count == DEPTH));
      chk("ovf",   32'(ovf_flag),   32'(m_ovf));
      chk("udf",   32'(udf_flag),   32'(m_udf));
      chk("irq",   32'(irq),        32'(m_irq));
      if (m_count > 0) begin
        chk("head", rd_data, sb[0]);
        if (rd_pop && reg_fifoen) void'(sb.pop_front());
      end else begin
        chk("head_empty", rd_data, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    SYSRST = 1'b1; reg_fifoen = 1'b0; reg_fifolvl = 5'd20;
    reg_lvlie = 1'b0; reg_ovfie = 1'b0; in_data = '0;
    in_valid = 1'b0; rd_pop = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge SYSCLK);
    #1 SYSRST = 1'b0;
    idle(2);

    // Basic FWFT behaviour
    reg_fifoen = 1'b1;
    step(1, 32'h11, 0, 0);
    chk("first_head", rd_data, 32'h11);
    chk("first_count", 32'(fifo_count), 32'd1);
    step(1, 32'h22, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("drained_udf", 32'(udf_flag), 32'd0);
    idle(1);

    // Overflow on the 17th word, then ordered drain and wrapped refill
    for (int i = 1; i <= 17; i++) step(1, 32'(i), 0, 0);
    chk("ovf17_full", 32'(fifo_full), 32'd1);
    chk("ovf17_flag", 32'(ovf_flag), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 101; i <= 116; i++) step(1, 32'(i), 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

    // Level interrupt, edge triggered
    reg_fifolvl = 5'd4; reg_lvlie = 1'b1;
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    chk("lvl_below", 32'(irq), 32'd0);
    step(1, $urandom, 0, 0);
    chk("lvl_hit", 32'(irq), 32'd1);
    step(1, $urandom, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("lvl_held", 32'(irq), 32'd1);
    step(0, 0, 0, 1);
    chk("lvl_clr", 32'(irq), 32'd0);
    step(1, $urandom, 0, 0);
    chk("lvl_rehit", 32'(irq), 32'd1);
    while (m_count > 0) step(0, 0, 1, 0);
    reg_lvlie = 1'b0; reg_fifolvl = 5'd20;
    step(0, 0, 0, 1);

    // Simultaneous push/pop at full and at empty
    while (m_count < DEPTH) step(1, $urandom, 0, 0);
    step(1, 32'hAA, 1, 0);
    chk("fullpp_ovf", 32'(ovf_flag), 32'd0);
    while (m_count > 0) step(0, 0, 1, 0);
    step(1, 32'h55, 1, 0);
    chk("emptypp_udf", 32'(udf_flag), 32'd1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Clear racing an overflow, then disable at count 7
    reg_ovfie = 1'b1;
    while (m_count < DEPTH) step(1, $urandom, 0, 0);
    step(1, 32'hBB, 0, 1);
    chk("clrovf_irq", 32'(irq), 32'd1);
    while (m_count > 7) step(0, 0, 1, 0);
    reg_fifoen = 1'b0;
    step(1, 32'hCC, 0, 0);
    chk("dis_count", 32'(fifo_count), 32'd0);
    step(1, 32'hDD, 1, 0);
    chk("dis_ovf_kept", 32'(ovf_flag), 32'd1);
    reg_fifoen = 1'b1;
    idle(1);

    // Asynchronous reset mid-cycle at count 9 with irq pending
    while (m_count < 9) step(1, $urandom, 0, 0);
    #1 SYSRST = 1'b1;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_irq",   32'(irq),        32'd0);
    chk("arst_ovf",   32'(ovf_flag),   32'd0);
    chk("arst_data",  rd_data,         32'd0);
    sb.delete(); m_count = 0; m_ovf = 0; m_udf = 0; m_irq = 0;
    @(posedge SYSCLK);
    #2 SYSRST = 1'b0;
    @(posedge SYSCLK);
    #1;
    step(1, 32'h77, 0, 0);
    chk("arst_push", 32'(fifo_count), 32'd1);
    step(0, 0, 0, 1);

    // Random traffic with occasional configuration changes
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        reg_fifolvl = 5'($urandom_range(0, 20));
        reg_lvlie   = 1'($urandom_range(0, 1));
        reg_ovfie   = 1'($urandom_range(0, 1));
      end
      reg_fifoen = ($urandom_range(0, 63) != 0);
      if ((i / 100) % 2 == 0)
        step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 15) == 0));
      else
        step(1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 15) == 0));
    end
    reg_fifoen = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
